// File: rtl/config_pkg.sv
// ---------------------------------------------------------------------------
// config_pkg -- core configuration record consumed by cfg_readout_unit.
//
// Holds the subset of the elaborated core configuration that the readout
// stream publishes. Numeric fields are 32-bit so that a readout can show how
// a wide value truncates into its narrower word slot. Feature flags are
// single bits.
// ---------------------------------------------------------------------------
package config_pkg;

   typedef struct packed {
      // Address and data widths
      int unsigned XLEN;
      int unsigned PLEN;
      int unsigned GPLEN;
      int unsigned FLen;
      // Issue and commit structure
      int unsigned NrCommitPorts;
      int unsigned NrIssuePorts;
      int unsigned NR_SB_ENTRIES;
      int unsigned NrWbPorts;
      // Cache geometry
      int unsigned ICACHE_SET_ASSOC;
      int unsigned DCACHE_SET_ASSOC;
      int unsigned ICACHE_INDEX_WIDTH;
      int unsigned DCACHE_INDEX_WIDTH;
      int unsigned ICACHE_LINE_WIDTH;
      int unsigned DCACHE_LINE_WIDTH;
      // Translation, return stack, PMP and branch prediction
      int unsigned InstrTlbEntries;
      int unsigned DataTlbEntries;
      int unsigned RASDepth;
      int unsigned NrPMPEntries;
      int unsigned BTBEntries;
      int unsigned BHTEntries;
      // ISA extensions and coprocessor interface
      bit          RVA;
      bit          RVB;
      bit          RVC;
      bit          RVD;
      bit          RVF;
      bit          RVH;
      bit          RVS;
      bit          RVU;
      bit          RVV;
      bit          RVZCB;
      bit          RVZCMP;
      bit          RVZiCond;
      bit          RVZicntr;
      bit          RVZihpm;
      bit          XF16;
      bit          XF16ALT;
      bit          XF8;
      bit          XFVec;
      bit          CvxifEn;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cfg_readout_unit_if.sv
// ---------------------------------------------------------------------------
// cfg_readout_unit_if -- control and stream signals of cfg_readout_unit.
//
//   start  : request a full readout stream
//   abort  : terminate the current stream
//   valid  : data holds a valid word
//   ready  : consumer accepts the word
//   data   : current 32-bit config word
//   idx    : index of the current word (0..8)
//   last   : current word is the final one
//   busy   : a stream is in progress
//   done   : one-cycle pulse after the final word is accepted
//
// modport master is the readout unit's side. modport slave is the side that
// requests streams and consumes words.
// ---------------------------------------------------------------------------
interface cfg_readout_unit_if;

   logic        start;
   logic        abort;
   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic [3:0]  idx;
   logic        last;
   logic        busy;
   logic        done;

   modport master (
      input  start, abort, ready,
      output valid, data, idx, last, busy, done
   );

   modport slave (
      output start, abort, ready,
      input  valid, data, idx, last, busy, done
   );

endinterface

// File: rtl/cfg_readout_unit.sv
// ---------------------------------------------------------------------------
// cfg_readout_unit -- streams the elaborated core configuration as nine
// 32-bit words over a valid/ready handshake.
//
// Words 0..7 are constants built from CVA6Cfg. Each field is LSB-truncated
// into its slot, and unused bits are zero. Word 8 is the XOR of words 0..7.
// It is accumulated at run time from the words actually accepted.
//
// Ports
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   start_i  : request a full readout stream (ignored while streaming or
//              when abort_i is also high)
//   abort_i  : end the current stream without a done pulse
//   valid_o  : data_o / idx_o / last_o hold a word
//   ready_i  : consumer accepts the word
//   data_o   : current config word
//   idx_o    : index of the current word, 0..8
//   last_o   : current word is word 8
//   busy_o   : a stream is in progress
//   done_o   : one-cycle pulse after word 8 is accepted
// ---------------------------------------------------------------------------
module cfg_readout_unit #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        abort_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] data_o,
   output logic [3:0]  idx_o,
   output logic        last_o,
   output logic        busy_o,
   output logic        done_o
);

   // ------------------------------------------------------------------
   // Constant word table
   // ------------------------------------------------------------------
   localparam logic [31:0] W0 = 32'hCFA6_0001;
   localparam logic [31:0] W1 = {8'(CVA6Cfg.FLen), 8'(CVA6Cfg.GPLEN),
                                 8'(CVA6Cfg.PLEN), 8'(CVA6Cfg.XLEN)};
   localparam logic [31:0] W2 = {13'd0,
                                 CVA6Cfg.CvxifEn, CVA6Cfg.XFVec, CVA6Cfg.XF8,
                                 CVA6Cfg.XF16ALT, CVA6Cfg.XF16, CVA6Cfg.RVZihpm,
                                 CVA6Cfg.RVZicntr, CVA6Cfg.RVZiCond,
                                 CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB, CVA6Cfg.RVV,
                                 CVA6Cfg.RVU, CVA6Cfg.RVS, CVA6Cfg.RVH,
                                 CVA6Cfg.RVF, CVA6Cfg.RVD, CVA6Cfg.RVC,
                                 CVA6Cfg.RVB, CVA6Cfg.RVA};
   localparam logic [31:0] W3 = {8'(CVA6Cfg.NrWbPorts), 8'(CVA6Cfg.NR_SB_ENTRIES),
                                 8'(CVA6Cfg.NrIssuePorts), 8'(CVA6Cfg.NrCommitPorts)};
   localparam logic [31:0] W4 = {8'(CVA6Cfg.DCACHE_INDEX_WIDTH),
                                 8'(CVA6Cfg.ICACHE_INDEX_WIDTH),
                                 8'(CVA6Cfg.DCACHE_SET_ASSOC),
                                 8'(CVA6Cfg.ICACHE_SET_ASSOC)};
   localparam logic [31:0] W5 = {16'(CVA6Cfg.DCACHE_LINE_WIDTH),
                                 16'(CVA6Cfg.ICACHE_LINE_WIDTH)};
   localparam logic [31:0] W6 = {8'(CVA6Cfg.NrPMPEntries), 8'(CVA6Cfg.RASDepth),
                                 8'(CVA6Cfg.DataTlbEntries), 8'(CVA6Cfg.InstrTlbEntries)};
   localparam logic [31:0] W7 = {16'(CVA6Cfg.BHTEntries), 16'(CVA6Cfg.BTBEntries)};

   function automatic logic [31:0] rom_word(input logic [2:0] sel);
      case (sel)
         3'd0:    rom_word = W0;
         3'd1:    rom_word = W1;
         3'd2:    rom_word = W2;
         3'd3:    rom_word = W3;
         3'd4:    rom_word = W4;
         3'd5:    rom_word = W5;
         3'd6:    rom_word = W6;
         default: rom_word = W7;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   typedef enum logic {
      IDLE,
      STREAM
   } state_e;

   state_e      state_q, state_d;
   logic        valid_q, valid_d;
   logic [31:0] data_q,  data_d;
   logic [3:0]  idx_q,   idx_d;
   logic        last_q,  last_d;
   logic        busy_q,  busy_d;
   logic        done_q,  done_d;
   logic [31:0] acc_q,   acc_d;

   logic        handshake;
   logic [3:0]  next_idx;

   assign handshake = valid_q & ready_i;
   assign next_idx  = idx_q + 4'd1;

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets its hold value first, so each path through
      // the case below is fully assigned and no latch is inferred.
      state_d = state_q;
      valid_d = valid_q;
      data_d  = data_q;
      idx_d   = idx_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      acc_d   = acc_q;

      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               state_d = STREAM;
               valid_d = 1'b1;
               data_d  = W0;
               idx_d   = 4'd0;
               last_d  = 1'b0;
               busy_d  = 1'b1;
               acc_d   = '0;
            end
         end

         STREAM: begin
            // A word handed over in the abort cycle still counts as
            // transferred, so it is folded into the checksum either way.
            if (handshake) begin
               acc_d = acc_q ^ data_q;
            end

            if (abort_i) begin
               state_d = IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
               busy_d  = 1'b0;
            end else if (handshake) begin
               if (last_q) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = next_idx;
                  last_d = (next_idx == 4'd8);
                  // Word 8 takes the checksum that includes the word being
                  // accepted now, so it has no bubble.
                  data_d = (next_idx == 4'd8) ? (acc_q ^ data_q)
                                              : rom_word(next_idx[2:0]);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // NOTE: state is written with non-blocking assignments so that every flop
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         acc_q   <= acc_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign idx_o   = idx_q;
   assign last_o  = last_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_cfg_readout_unit.sv
// ---------------------------------------------------------------------------
// tb_cfg_readout_unit -- scoreboard bench for cfg_readout_unit.
//
// Stimulus pushes the expected word stream into a queue when it issues a
// start. A separate monitor pops and compares on every accepted word. The
// expected words come from a reference model that builds each word
// arithmetically from the configuration record.
// ---------------------------------------------------------------------------
module tb_cfg_readout_unit;

   // Configuration under readout. Some values are wider than their slots,
   // so the readout must show them truncated.
   localparam config_pkg::cva6_cfg_t TB_CFG = '{
      XLEN: 64, PLEN: 56, GPLEN: 41, FLen: 64,
      NrCommitPorts: 2, NrIssuePorts: 1, NR_SB_ENTRIES: 8, NrWbPorts: 5,
      ICACHE_SET_ASSOC: 4, DCACHE_SET_ASSOC: 8,
      ICACHE_INDEX_WIDTH: 300, DCACHE_INDEX_WIDTH: 12,
      ICACHE_LINE_WIDTH: 128, DCACHE_LINE_WIDTH: 32'h0001_0100,
      InstrTlbEntries: 16, DataTlbEntries: 16, RASDepth: 2, NrPMPEntries: 8,
      BTBEntries: 32, BHTEntries: 128,
      RVC: 1'b1, RVH: 1'b1,
      default: 0
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cfg_readout_unit_if bus ();

   cfg_readout_unit #(.CVA6Cfg(TB_CFG)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (bus.start),
      .abort_i (bus.abort),
      .valid_o (bus.valid),
      .ready_i (bus.ready),
      .data_o  (bus.data),
      .idx_o   (bus.idx),
      .last_o  (bus.last),
      .busy_o  (bus.busy),
      .done_o  (bus.done)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: each word computed from the configuration with plain
   // arithmetic. Slot truncation is modulo of the slot size.
   // ------------------------------------------------------------------
   function automatic int unsigned pack4x8(input int unsigned a, b, c, d);
      return (a % 256) + (b % 256) * 256 + (c % 256) * 65536 + (d % 256) * 16777216;
   endfunction

   function automatic int unsigned pack2x16(input int unsigned a, b);
      return (a % 65536) + (b % 65536) * 65536;
   endfunction

   function automatic logic [31:0] model_word(input int i);
      int unsigned flags [19];
      int unsigned w;
      flags = '{TB_CFG.RVA, TB_CFG.RVB, TB_CFG.RVC, TB_CFG.RVD, TB_CFG.RVF,
                TB_CFG.RVH, TB_CFG.RVS, TB_CFG.RVU, TB_CFG.RVV, TB_CFG.RVZCB,
                TB_CFG.RVZCMP, TB_CFG.RVZiCond, TB_CFG.RVZicntr, TB_CFG.RVZihpm,
                TB_CFG.XF16, TB_CFG.XF16ALT, TB_CFG.XF8, TB_CFG.XFVec, TB_CFG.CvxifEn};
      case (i)
         0: w = 32'hCFA60001;
         1: w = pack4x8(TB_CFG.XLEN, TB_CFG.PLEN, TB_CFG.GPLEN, TB_CFG.FLen);
         2: begin
            w = 0;
            for (int b = 0; b < 19; b++) w = w + flags[b] * (1 << b);
         end
         3: w = pack4x8(TB_CFG.NrCommitPorts, TB_CFG.NrIssuePorts,
                        TB_CFG.NR_SB_ENTRIES, TB_CFG.NrWbPorts);
         4: w = pack4x8(TB_CFG.ICACHE_SET_ASSOC, TB_CFG.DCACHE_SET_ASSOC,
                        TB_CFG.ICACHE_INDEX_WIDTH, TB_CFG.DCACHE_INDEX_WIDTH);
         5: w = pack2x16(TB_CFG.ICACHE_LINE_WIDTH, TB_CFG.DCACHE_LINE_WIDTH);
         6: w = pack4x8(TB_CFG.InstrTlbEntries, TB_CFG.DataTlbEntries,
                        TB_CFG.RASDepth, TB_CFG.NrPMPEntries);
         7: w = pack2x16(TB_CFG.BTBEntries, TB_CFG.BHTEntries);
         default: begin
            w = 0;
            for (int k = 0; k < 8; k++) w = w ^ model_word(k);
         end
      endcase
      return w;
   endfunction

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q [$];

   task automatic push_stream();
      for (int i = 0; i < 9; i++) exp_q.push_back('{i, model_word(i), i == 8});
   endtask

   // ------------------------------------------------------------------
   // Monitor: compares every accepted word and checks that a stalled word
   // stays put.
   // ------------------------------------------------------------------
   logic [31:0] rx     [9];
   int          rx_cyc [9];

   initial begin
      logic        held;
      logic [31:0] held_data;
      logic [3:0]  held_idx;
      logic        held_last;
      exp_t        e;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || !bus.valid) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("stall_data", bus.data, held_data);
               check("stall_idx", 32'(bus.idx), 32'(held_idx));
               check("stall_last", 32'(bus.last), 32'(held_last));
            end
            if (bus.ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_word_idx", 32'(bus.idx), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("word_idx", 32'(bus.idx), 32'(e.idx));
                  check("word_data", bus.data, e.data);
                  check("word_last", 32'(bus.last), 32'(e.last));
               end
               if (bus.idx < 9) begin
                  rx[bus.idx]     = bus.data;
                  rx_cyc[bus.idx] = cyc;
               end
               held = 1'b0;
            end else begin
               held      = 1'b1;
               held_data = bus.data;
               held_idx  = bus.idx;
               held_last = bus.last;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic clear_rx();
      for (int i = 0; i < 9; i++) begin
         rx[i]     = '0;
         rx_cyc[i] = -100;
      end
   endtask

   task automatic begin_stream();
      clear_rx();
      push_stream();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("first_valid", 32'(bus.valid), 32'd1);
      check("first_idx", 32'(bus.idx), 32'd0);
      check("first_busy", 32'(bus.busy), 32'd1);
   endtask

   // Waits, with ready held high, until word n is on the bus.
   task automatic wait_idx(input int n);
      int budget;
      budget = 0;
      while (!(bus.valid && bus.idx == 4'(n)) && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("wait_idx_reached", 32'(bus.valid && bus.idx == 4'(n)), 32'd1);
   endtask

   task automatic finish_stream(input bit rnd);
      int          n;
      bit          got;
      logic [31:0] x;
      n   = 0;
      got = 1'b0;
      while (n < 400 && !got) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) got = 1'b1;
         else if (rnd) bus.ready = 1'($urandom_range(0, 1));
      end
      bus.ready = 1'b1;
      check("done_seen", 32'(got), 32'd1);
      check("done_valid_low", 32'(bus.valid), 32'd0);
      check("done_busy_low", 32'(bus.busy), 32'd0);
      check("done_cycle", 32'(cyc), 32'(rx_cyc[8] + 1));
      x = '0;
      for (int i = 0; i < 8; i++) x = x ^ rx[i];
      check("w8_xor_of_received", rx[8], x);
      if (!rnd) check("stream_cycles", 32'(rx_cyc[8] - rx_cyc[0]), 32'd8);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_constants();
      check("w0_magic", rx[0], 32'hCFA6_0001);
      check("w1_widths", rx[1], 32'h4029_3840);
      check("w2_isa", rx[2], 32'h0000_0024);
   endtask

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.ready = 1'b1;
      clear_rx();

      // Reset state
      #12;
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_data", bus.data, 32'd0);
      check("rst_idx", 32'(bus.idx), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // start together with abort in IDLE does nothing
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("start_abort_idle_valid", 32'(bus.valid), 32'd0);
      check("start_abort_idle_busy", 32'(bus.busy), 32'd0);

      // Full stream at full throughput
      begin_stream();
      finish_stream(1'b0);
      check_constants();

      // Random backpressure
      for (int r = 0; r < 4; r++) begin
         bus.ready = 1'($urandom_range(0, 1));
         begin_stream();
         finish_stream(1'b1);
      end

      // Abort at idx 4 while a handshake happens in the same cycle
      begin_stream();
      wait_idx(4);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      check("abort_valid_low", 32'(bus.valid), 32'd0);
      check("abort_busy_low", 32'(bus.busy), 32'd0);
      check("abort_words_taken", 32'(exp_q.size()), 32'd4);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         check("abort_no_done", 32'(bus.done), 32'd0);
         @(posedge clk);
         #1;
      end
      begin_stream();
      finish_stream(1'b0);

      // start pulsed mid-stream is ignored
      begin_stream();
      wait_idx(3);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("restart_ignored_idx", 32'(bus.idx), 32'd4);
      check("restart_ignored_valid", 32'(bus.valid), 32'd1);
      finish_stream(1'b0);

      // Asynchronous reset at idx 6 with ready low
      begin_stream();
      wait_idx(6);
      bus.ready = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.valid), 32'd0);
      check("arst_data", bus.data, 32'd0);
      check("arst_idx", 32'(bus.idx), 32'd0);
      check("arst_last", 32'(bus.last), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.ready = 1'b1;
      @(posedge clk);
      #1;
      begin_stream();
      finish_stream(1'b0);
      check_constants();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/cfg_readout_unit.md
CFG_READOUT_UNIT -- requirements
Module: cfg_readout_unit

Interface
REQ-001 The block SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, meaning the elaborated core configuration to be read out.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: request a full readout stream.
REQ-005 The block SHALL have port abort_i, input, 1 bit: terminate the current stream.
REQ-006 The block SHALL have port valid_o, output, 1 bit: data_o holds a valid word.
REQ-007 The block SHALL have port ready_i, input, 1 bit: the consumer accepts the word.
REQ-008 The block SHALL have port data_o, output, 32 bits: the current config word.
REQ-009 The block SHALL have port idx_o, output, 4 bits: index of the current word.
REQ-010 The block SHALL have port last_o, output, 1 bit: the current word is the final word (idx 8).
REQ-011 The block SHALL have port busy_o, output, 1 bit: a stream is in progress.
REQ-012 The block SHALL have port done_o, output, 1 bit: one-cycle pulse after the final word is accepted.

Function
REQ-013 The word table SHALL hold 9 words; every field SHALL be the LSB-truncated value of the named CVA6Cfg field, and unused bits SHALL be 0.
- W0 = 0xCFA60001 (magic and version).
- W1 = [7:0] XLEN, [15:8] PLEN, [23:16] GPLEN, [31:24] FLen.
- W2 = [0] RVA, [1] RVB, [2] RVC, [3] RVD, [4] RVF, [5] RVH, [6] RVS, [7] RVU, [8] RVV, [9] RVZCB, [10] RVZCMP, [11] RVZiCond, [12] RVZicntr, [13] RVZihpm, [14] XF16, [15] XF16ALT, [16] XF8, [17] XFVec, [18] CvxifEn.
- W3 = [7:0] NrCommitPorts, [15:8] NrIssuePorts, [23:16] NR_SB_ENTRIES, [31:24] NrWbPorts.
- W4 = [7:0] ICACHE_SET_ASSOC, [15:8] DCACHE_SET_ASSOC, [23:16] ICACHE_INDEX_WIDTH, [31:24] DCACHE_INDEX_WIDTH.
- W5 = [15:0] ICACHE_LINE_WIDTH, [31:16] DCACHE_LINE_WIDTH.
- W6 = [7:0] InstrTlbEntries, [15:8] DataTlbEntries, [23:16] RASDepth, [31:24] NrPMPEntries.
- W7 = [15:0] BTBEntries, [31:16] BHTEntries.
- W8 = XOR of W0..W7, accumulated at run time by a register updated on each accepted word (not a constant).
REQ-014 The FSM SHALL have the states IDLE and STREAM.
REQ-015 In IDLE, start_i=1 and abort_i=0 SHALL move the FSM to STREAM and, on the next cycle, drive valid_o=1, idx_o=0, data_o=W0, busy_o=1, and clear the checksum accumulator.
REQ-016 In STREAM, the word is accepted on any cycle with valid_o=1 and ready_i=1; on acceptance the accumulator SHALL be XORed with data_o and idx_o SHALL advance, with the next word valid on the next cycle (no bubble).
REQ-017 While valid_o=1 and ready_i=0, data_o, idx_o and last_o SHALL remain stable.
REQ-018 Acceptance of W8 SHALL return the FSM to IDLE, with valid_o=0, busy_o=0 and done_o=1 for exactly one cycle.
REQ-019 start_i while in STREAM SHALL be ignored.
REQ-020 abort_i in STREAM SHALL return the FSM to IDLE on the next cycle with valid_o=0 and no done_o; if a handshake occurs in the same cycle, that word counts as transferred, but abort still wins.
REQ-021 start_i together with abort_i in IDLE SHALL be ignored.
REQ-022 Throughput SHALL be one word per cycle with ready_i held at 1; a full stream SHALL take 9 cycles from the first valid_o.
REQ-023 All outputs SHALL be registered; idx_o SHALL never exceed 8.

Reset
REQ-024 rst_i=1 SHALL force, asynchronously: state IDLE, valid_o=0, data_o=0, idx_o=0, last_o=0, busy_o=0, done_o=0, accumulator=0.
REQ-025 Reset asserted mid-stream SHALL discard the stream; after release the block SHALL accept a new start_i normally.

Verification
REQ-026 Bench SHALL cover: CVA6Cfg XLEN=64, PLEN=56, GPLEN=41, FLen=64, start_i pulse, ready_i=1 -> W0=0xCFA60001 then W1=0x40293840, 9 consecutive words, done_o one cycle after W8.
REQ-027 Bench SHALL cover: ready_i toggling randomly -> each word held stable until accepted, word order 0..8 preserved, W8 equal to the XOR of the received W0..W7.
REQ-028 Bench SHALL cover: abort_i at idx 4 -> valid_o=0 next cycle, no done_o; a new start_i then restarts at idx 0 with a fresh checksum.
REQ-029 Bench SHALL cover: start_i pulsed at idx 3 -> ignored, stream continues at idx 4.
REQ-030 Bench SHALL cover: rst_i asserted at idx 6 with ready_i=0 -> all outputs 0 immediately; after release, a full stream matches REQ-026.
REQ-031 Bench SHALL cover: RVC=1, RVH=1, all other W2 bits 0 -> W2=0x00000024.
